// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: ID/EX hazard sources in, pipeline register controls and perf counters out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IfId_rs;
  logic [4:0]       IfId_rt;
  logic             IfId_uses_rt;
  logic             IfId_hilo;
  logic             IfId_muldiv;
  logic [4:0]       IdEx_rt;
  logic             IdEx_MemRead;
  logic             IdEx_muldiv;
  logic             Ex_branch_taken;
  logic             PCWrite;
  logic             IfIdWrite;
  logic             IdEx_bubble;
  logic             IfId_flush;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IfId_rs, IfId_rt, IfId_uses_rt, IfId_hilo, IfId_muldiv,
           IdEx_rt, IdEx_MemRead, IdEx_muldiv, Ex_branch_taken,
    input  PCWrite, IfIdWrite, IdEx_bubble, IfId_flush, muldiv_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  IfId_rs, IfId_rt, IfId_uses_rt, IfId_hilo, IfId_muldiv,
           IdEx_rt, IdEx_MemRead, IdEx_muldiv, Ex_branch_taken,
    output PCWrite, IfIdWrite, IdEx_bubble, IfId_flush, muldiv_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall/flush controller with mul/div busy tracking.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] LAT  = 8'(MULDIV_LAT);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load_use;
  logic       md_hz;
  logic       hazard;
  logic       branch;

  assign load_use = bus.IdEx_MemRead && (bus.IdEx_rt != 5'd0) &&
                    ((bus.IdEx_rt == bus.IfId_rs) ||
                     (bus.IfId_uses_rt && (bus.IdEx_rt == bus.IfId_rt)));
  assign md_hz    = (bus.IfId_hilo || bus.IfId_muldiv) &&
                    ((state_q == BUSY) || bus.IdEx_muldiv);
  assign hazard   = load_use || md_hz;
  assign branch   = bus.Ex_branch_taken;

  // A taken branch squashes the ID instruction, so its stall request is dropped.
  assign bus.PCWrite     = branch || !hazard;
  assign bus.IfIdWrite   = branch || !hazard;
  assign bus.IdEx_bubble = branch || hazard;
  assign bus.IfId_flush  = branch;
  assign bus.muldiv_busy = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.IdEx_muldiv) begin
          state_d = BUSY;
          cnt_d   = LAT;
        end
      end
      default: begin
        // A new mul/div is only legal on the final busy cycle; earlier starts are ignored.
        if (cnt_q == 8'd1) begin
          if (bus.IdEx_muldiv) begin
            cnt_d = LAT;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign stall_d = bus.PCWrite    ? stall_q : sat_inc(stall_q);
  assign flush_d = bus.IfId_flush ? sat_inc(flush_q) : flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MULDIV_LAT=4, CNT_W=4 so saturation is reachable).
module tb_hazard_stall_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_flush;

  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.IfId_rs         = 5'd0;
    bus.IfId_rt         = 5'd0;
    bus.IfId_uses_rt    = 1'b0;
    bus.IfId_hilo       = 1'b0;
    bus.IfId_muldiv     = 1'b0;
    bus.IdEx_rt         = 5'd0;
    bus.IdEx_MemRead    = 1'b0;
    bus.IdEx_muldiv     = 1'b0;
    bus.Ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1100",
               {bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush});
    end
    checks++;
    if (bus.muldiv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus.muldiv_busy);
    end
    checks++;
    if (bus.stall_cycles !== 4'd0 || bus.flush_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.stall_cycles, bus.flush_count);
    end
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use_rs();
    bus.IdEx_MemRead = 1'b1;
    bus.IdEx_rt      = 5'd5;
    bus.IfId_rs      = 5'd5;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL lu_rs_stall got %b exp 0010",
               {bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush});
    end
    tick();
    exp_stall++;
    bus.IdEx_MemRead = 1'b0;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble} !== 3'b110) begin
      errors++;
      $display("FAIL lu_rs_resume got %b exp 110",
               {bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble});
    end
    checks++;
    if (bus.stall_cycles !== CW'(PERF ? exp_stall : 0)) begin
      errors++;
      $display("FAIL lu_rs_count got %0d exp %0d", bus.stall_cycles, PERF ? exp_stall : 0);
    end
    clear_inputs();
  endtask

  task automatic test_load_r0();
    bus.IdEx_MemRead = 1'b1;
    bus.IdEx_rt      = 5'd0;
    bus.IfId_rs      = 5'd0;
    bus.IfId_rt      = 5'd0;
    bus.IfId_uses_rt = 1'b1;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IdEx_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL load_r0 got %b exp 10", {bus.PCWrite, bus.IdEx_bubble});
    end
    clear_inputs();
  endtask

  task automatic test_load_rt();
    bus.IdEx_MemRead = 1'b1;
    bus.IdEx_rt      = 5'd7;
    bus.IfId_rt      = 5'd7;
    bus.IfId_rs      = 5'd3;
    bus.IfId_uses_rt = 1'b0;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IdEx_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL load_rt_unused got %b exp 10", {bus.PCWrite, bus.IdEx_bubble});
    end
    bus.IfId_uses_rt = 1'b1;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL load_rt_used got %b exp 001",
               {bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble});
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_muldiv_hilo();
    bus.IdEx_muldiv = 1'b1;
    bus.IfId_hilo   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.PCWrite !== ((i < 5) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL mfhi_pcwrite cyc %0d got %b exp %b", i, bus.PCWrite, (i < 5) ? 1'b0 : 1'b1);
      end
      checks++;
      if (bus.muldiv_busy !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL mfhi_busy cyc %0d got %b exp %b", i, bus.muldiv_busy,
                 (i >= 1 && i <= 4) ? 1'b1 : 1'b0);
      end
      tick();
      bus.IdEx_muldiv = 1'b0;
    end
    exp_stall += 5;
    clear_inputs();
    #1;
    checks++;
    if (bus.stall_cycles !== CW'(PERF ? exp_stall : 0)) begin
      errors++;
      $display("FAIL mfhi_count got %0d exp %0d", bus.stall_cycles, PERF ? exp_stall : 0);
    end
  endtask

  task automatic test_muldiv_reload();
    bus.IdEx_muldiv = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      bus.IdEx_muldiv = (i == 4);
      #1;
      checks++;
      if (bus.muldiv_busy !== ((i <= 8) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL reload_busy cyc %0d got %b exp %b", i, bus.muldiv_busy, (i <= 8) ? 1'b1 : 1'b0);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    bus.IdEx_MemRead    = 1'b1;
    bus.IdEx_rt         = 5'd5;
    bus.IfId_rs         = 5'd5;
    bus.Ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush} !== 4'b1111) begin
      errors++;
      $display("FAIL branch_lu got %b exp 1111",
               {bus.PCWrite, bus.IfIdWrite, bus.IdEx_bubble, bus.IfId_flush});
    end
    tick();
    exp_flush++;
    clear_inputs();
    #1;
    checks++;
    if (bus.flush_count !== CW'(PERF ? exp_flush : 0) ||
        bus.stall_cycles !== CW'(PERF ? exp_stall : 0)) begin
      errors++;
      $display("FAIL branch_count got %0d/%0d exp %0d/%0d", bus.flush_count, bus.stall_cycles,
               PERF ? exp_flush : 0, PERF ? exp_stall : 0);
    end
    // Branch while busy: mul/div keeps running, squashed mfhi does not stall.
    bus.IdEx_muldiv = 1'b1;
    tick();
    bus.IdEx_muldiv     = 1'b0;
    bus.Ex_branch_taken = 1'b1;
    bus.IfId_hilo       = 1'b1;
    #1;
    checks++;
    if ({bus.PCWrite, bus.IfId_flush} !== 2'b11) begin
      errors++;
      $display("FAIL branch_busy_ctrl got %b exp 11", {bus.PCWrite, bus.IfId_flush});
    end
    tick();
    exp_flush++;
    clear_inputs();
    #1;
    checks++;
    if (bus.muldiv_busy !== 1'b1) begin
      errors++;
      $display("FAIL branch_busy_kept got %b exp 1", bus.muldiv_busy);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.muldiv_busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_busy_drain got %b exp 0", bus.muldiv_busy);
    end
  endtask

  task automatic test_reset_busy();
    bus.IdEx_muldiv = 1'b1;
    bus.IfId_hilo   = 1'b1;
    tick();
    bus.IdEx_muldiv = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.muldiv_busy !== 1'b0 || bus.PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_state got %b%b exp 01", bus.muldiv_busy, bus.PCWrite);
    end
    checks++;
    if (bus.stall_cycles !== 4'd0 || bus.flush_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_busy_cnt got %0d/%0d exp 0/0", bus.stall_cycles, bus.flush_count);
    end
    exp_stall = 0;
    exp_flush = 0;
    clear_inputs();
  endtask

  task automatic test_saturation();
    bus.IdEx_MemRead = 1'b1;
    bus.IdEx_rt      = 5'd9;
    bus.IfId_rs      = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    bus.Ex_branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.stall_cycles !== CW'(PERF ? 15 : 0)) begin
      errors++;
      $display("FAIL sat_stall got %0d exp %0d", bus.stall_cycles, PERF ? 15 : 0);
    end
    checks++;
    if (bus.flush_count !== CW'(PERF ? 15 : 0)) begin
      errors++;
      $display("FAIL sat_flush got %0d exp %0d", bus.flush_count, PERF ? 15 : 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    exp_flush = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use_rs();
    test_load_r0();
    test_load_rt();
    test_muldiv_hilo();
    test_muldiv_reload();
    test_branch();
    test_reset_busy();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

- Sequences the 5-stage pipeline around hazards the forwarding path cannot resolve.
- Sits beside the forwarding unit in the ID/EX region and drives the PC, IF/ID and ID/EX register controls:
  - stalls one cycle on a load-use dependency;
  - stalls while the multi-cycle mul/div unit is busy and a HI/LO consumer or a second mul/div is in ID;
  - flushes wrong-path instructions on a taken branch.
- Optionally keeps saturating performance counters.

## Interface
Parameters:
- MULDIV_LAT, 32, number of busy cycles after a mul/div leaves EX; legal range 2..255
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clk edge where reset=1
- IfId_rs  in  5  rs field of the instruction in ID
- IfId_rt  in  5  rt field of the instruction in ID
- IfId_uses_rt  in  1  ID instruction reads rt as a source
- IfId_hilo  in  1  ID instruction is mfhi/mflo
- IfId_muldiv  in  1  ID instruction is mult/multu/div/divu
- IdEx_rt  in  5  destination of the instruction in EX
- IdEx_MemRead  in  1  EX instruction is a load
- IdEx_muldiv  in  1  EX instruction is a mul/div; the unit starts this cycle
- Ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- IfIdWrite  out  1  IF/ID register write enable
- IdEx_bubble  out  1  load NOP controls into ID/EX at next edge
- IfId_flush  out  1  clear IF/ID to NOP at next edge
- muldiv_busy  out  1  mul/div unit still computing
- stall_cycles  out  CNT_W  cycles with PCWrite=0 (perf)
- flush_count  out  CNT_W  taken-branch flushes (perf)

## Operation
- Mealy outputs: combinational from registered state plus current inputs; no output register.
- Define:
  - load_use = IdEx_MemRead & (IdEx_rt != 0) & ((IdEx_rt == IfId_rs) | (IfId_uses_rt & (IdEx_rt == IfId_rt)))
  - md_hz = (IfId_hilo | IfId_muldiv) & (muldiv_busy | IdEx_muldiv)
- Priority:
  1. Ex_branch_taken: PCWrite=1, IfIdWrite=1, IfId_flush=1, IdEx_bubble=1. Any stall request for the squashed ID instruction is ignored.
  2. load_use or md_hz: PCWrite=0, IfIdWrite=0, IdEx_bubble=1, IfId_flush=0.
  3. Otherwise: PCWrite=1, IfIdWrite=1, IdEx_bubble=0, IfId_flush=0.
- Mul/div FSM states:
  - IDLE: muldiv_busy=0. IdEx_muldiv=1 → BUSY, with cnt=MULDIV_LAT.
  - BUSY: muldiv_busy=1; cnt decrements each cycle. At cnt==1 → IDLE, or → BUSY with cnt reloaded if IdEx_muldiv=1 that cycle.
- IdEx_muldiv=1 while in BUSY with cnt>1 is a protocol violation. md_hz guarantees it cannot occur, and the block ignores it.
- A taken branch does not disturb BUSY: the mul/div already in EX is committed.
- Load-use stall lasts one cycle. The bubble clears IdEx_MemRead, and the forwarding unit then supplies MEM→EX data.
- Register 0 never causes a load-use stall.

## Timing
- Reset values:
  - state=IDLE, cnt=0, muldiv_busy=0
  - stall_cycles=0, flush_count=0
  - with IDLE state and all inputs 0: PCWrite=1, IfIdWrite=1, IdEx_bubble=0, IfId_flush=0
- Stall and flush outputs respond in the same cycle as their inputs (zero latency).
- muldiv_busy rises the cycle after IdEx_muldiv=1 and stays high exactly MULDIV_LAT cycles. md_hz covers the start cycle through IdEx_muldiv.
- A HI/LO consumer entering ID right behind a mul/div stalls MULDIV_LAT+1 cycles.
- Reset asserted mid-BUSY: returns to IDLE at that edge, and outputs revert to pass-through the same cycle.
- Counters:
  - stall_cycles increments on each edge where PCWrite=0.
  - flush_count increments on each edge where IfId_flush=1.
  - Both saturate at 2^CNT_W-1, with no wrap.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles and flush_count are implemented as above.
- HAZARD_PERF_EN undefined: no counter flops; both outputs are constant 0. Stall and flush behaviour is identical.

## Test plan
- Load-use on rs:
  - Stimulus: IdEx_MemRead=1, IdEx_rt=5, IfId_rs=5.
  - Response: PCWrite=0, IfIdWrite=0, IdEx_bubble=1 for 1 cycle. With MemRead dropped the next cycle, pass-through resumes and stall_cycles=1.
- Load to $0:
  - Stimulus: IdEx_rt=0, IfId_rs=0, IdEx_MemRead=1.
  - Response: no stall.
- Load on rt with IfId_uses_rt=0:
  - Response: no stall.
- Mul/div followed by mfhi, MULDIV_LAT=4:
  - Stimulus: IdEx_muldiv=1, then IfId_hilo=1 held.
  - Response: PCWrite=0 for 5 cycles; muldiv_busy high for 4 cycles; PCWrite=1 on the 6th cycle.
- Taken branch with simultaneous load-use:
  - Response: IfId_flush=1, IdEx_bubble=1, PCWrite=1; flush_count increments; stall_cycles unchanged.
- Reset during BUSY:
  - Stimulus: reset=1 for 1 cycle, cnt=3.
  - Response: muldiv_busy=0 the next cycle; counters read 0.
